// File: rtl/regfile_dump_reader.sv
// Sweeps the CPU debug register-read port, streams each register over valid/ready
// and keeps an XOR checksum of the last completed dump.
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS      = 32,
   parameter int unsigned SEL_W         = 5,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   output logic [SEL_W-1:0] reg_sel,
   input  logic [31:0]      reg_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [SEL_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic [31:0]      checksum
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SEND   = 2'd2;

   logic [1:0]        state_q,  state_d;
   logic [SEL_W-1:0]  sel_q,    sel_d;
   logic [DATA_W-1:0] data_q,   data_d;
   logic [SEL_W-1:0]  idx_q,    idx_d;
   logic              last_q,   last_d;
   logic              valid_q,  valid_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic [DATA_W-1:0] chk_q,    chk_d;
   logic [DATA_W-1:0] acc_q,    acc_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         chk_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         chk_q   <= chk_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output logic; abort overrides every other event
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      chk_d   = chk_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;

      if (abort) begin
         state_d = ST_IDLE;
         sel_d   = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sel_d   = '0;
               valid_d = 1'b0;
               if (start) begin
                  acc_d   = '0;
                  cnt_d   = CNT_INIT;
                  busy_d  = 1'b1;
                  state_d = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  data_d  = reg_data;
                  idx_d   = sel_q;
                  last_d  = (sel_q == LAST_SEL);
                  valid_d = 1'b1;
                  state_d = ST_SEND;
               end
            end
            ST_SEND: begin
               if (valid_q && out_ready) begin
                  acc_d   = acc_q ^ data_q;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  if (last_q) begin
                     chk_d   = acc_q ^ data_q;
                     done_d  = 1'b1;
                     sel_d   = '0;
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     sel_d   = sel_q + SEL_ONE;
                     cnt_d   = CNT_INIT;
                     state_d = ST_SETTLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               sel_d   = '0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign reg_sel   = sel_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign checksum  = chk_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven dumps plus latency, abort and reset sequences.
module tb_regfile_dump_reader;

   localparam int unsigned NR = 32;
   localparam int unsigned SW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;

   // Instance A: SETTLE_CYCLES = 1
   logic          a_start, a_abort, a_ready;
   logic [SW-1:0] a_sel, a_idx;
   logic [31:0]   a_rdata, a_data, a_chk;
   logic          a_valid, a_last, a_busy, a_done;
   logic [31:0]   regs_a [NR];
   assign a_rdata = regs_a[a_sel];

   // Instance B: SETTLE_CYCLES = 3
   logic          b_start, b_abort, b_ready;
   logic [SW-1:0] b_sel, b_idx;
   logic [31:0]   b_rdata, b_data, b_chk;
   logic          b_valid, b_last, b_busy, b_done;
   logic [31:0]   regs_b [NR];
   assign b_rdata = regs_b[b_sel];

   regfile_dump_reader #(.NUM_REGS(NR), .SEL_W(SW), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rstn(rstn), .start(a_start), .abort(a_abort),
      .reg_sel(a_sel), .reg_data(a_rdata), .out_valid(a_valid), .out_ready(a_ready),
      .out_data(a_data), .out_idx(a_idx), .out_last(a_last), .busy(a_busy),
      .done(a_done), .checksum(a_chk));

   regfile_dump_reader #(.NUM_REGS(NR), .SEL_W(SW), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rstn(rstn), .start(b_start), .abort(b_abort),
      .reg_sel(b_sel), .reg_data(b_rdata), .out_valid(b_valid), .out_ready(b_ready),
      .out_data(b_data), .out_idx(b_idx), .out_last(b_last), .busy(b_busy),
      .done(b_done), .checksum(b_chk));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] r3;
      int          mode;      // 0: ready=1, 1: ready 1,0,0 repeating, 2: random ready
      int          restart;   // idx at which a stray start is pulsed, -1 for none
      logic [31:0] exp_chk;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stub_regs(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
      for (int i = 0; i < NR; i++) regs_a[i] = 32'h0;
      regs_a[1] = r1;
      regs_a[2] = r2;
      regs_a[3] = r3;
   endtask

   // Drives one full dump on instance A and checks the word stream against regs_a
   task automatic run_dump(input int mode, input int restart, input logic [31:0] exp_chk,
                           input string tag);
      int          nexp;
      int          cyc;
      bit          seen_done;
      bit          hold;
      logic [31:0] hd;
      logic [SW-1:0] hi;
      logic [31:0] model;
      nexp = 0; cyc = 0; seen_done = 0; hold = 0; hd = '0; hi = '0; model = '0;
      a_start = 1'b1;
      a_ready = 1'b0;
      step();
      a_start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(a_busy), 32'd1);
      while (!seen_done && cyc < 3000) begin
         a_start = 1'b0;
         if (a_valid) begin
            if (hold) begin
               chk({tag, " stall_data"}, a_data, hd);
               chk({tag, " stall_idx"}, 32'(a_idx), 32'(hi));
            end else begin
               chk({tag, " idx"}, 32'(a_idx), 32'(nexp));
               chk({tag, " data"}, a_data, regs_a[nexp % NR]);
               chk({tag, " last"}, 32'(a_last), 32'(nexp == NR - 1));
               hd = a_data;
               hi = a_idx;
               if (restart >= 0 && nexp == restart) a_start = 1'b1;
            end
         end
         case (mode)
            0:       a_ready = 1'b1;
            1:       a_ready = (cyc % 3 == 0);
            default: a_ready = 1'($urandom_range(0, 1));
         endcase
         if (a_valid && a_ready) begin
            model ^= a_data;
            nexp++;
            hold = 1'b0;
         end else begin
            hold = a_valid;
         end
         step();
         cyc++;
         if (a_done) begin
            seen_done = 1'b1;
            chk({tag, " busy_at_done"}, 32'(a_busy), 32'd0);
            chk({tag, " word_count"}, 32'(nexp), 32'(NR));
            chk({tag, " checksum"}, a_chk, exp_chk);
            chk({tag, " checksum_vs_stream"}, a_chk, model);
         end
      end
      a_start = 1'b0;
      if (!seen_done) chk({tag, " done_timeout"}, 32'd0, 32'd1);
      a_ready = 1'b0;
      step();
      chk({tag, " done_single_pulse"}, 32'(a_done), 32'd0);
      chk({tag, " idle_valid"}, 32'(a_valid), 32'd0);
   endtask

   vec_t vt [4];

   initial begin
      vt[0] = '{32'h11, 32'h22, 32'h44, 0, -1, 32'h77};
      vt[1] = '{32'h11, 32'h22, 32'h44, 1, -1, 32'h77};
      vt[2] = '{32'hdeadbeef, 32'h0, 32'hdeadbeef, 2, -1, 32'h0};
      vt[3] = '{32'h1, 32'h2, 32'h4, 0, 10, 32'h7};

      rstn = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
      b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         regs_a[i] = 32'h0;
         regs_b[i] = 32'h1000 + 32'(i);
      end
      step();
      step();
      chk("reset sel", 32'(a_sel), 32'd0);
      chk("reset valid", 32'(a_valid), 32'd0);
      chk("reset busy", 32'(a_busy), 32'd0);
      chk("reset done", 32'(a_done), 32'd0);
      chk("reset checksum", a_chk, 32'd0);
      chk("reset data", a_data, 32'd0);
      rstn = 1'b1;
      step();

      foreach (vt[k]) begin
         stub_regs(vt[k].r1, vt[k].r2, vt[k].r3);
         run_dump(vt[k].mode, vt[k].restart, vt[k].exp_chk, $sformatf("vec%0d", k));
      end

      // Random register file, random ready, checksum from a plain XOR over the array
      for (int r = 0; r < 2; r++) begin
         logic [31:0] x;
         x = '0;
         for (int i = 0; i < NR; i++) begin
            regs_a[i] = $urandom;
            x ^= regs_a[i];
         end
         run_dump(2, -1, x, $sformatf("rand%0d", r));
      end

      // Abort while idx 5 is offered with ready high
      stub_regs(32'h11, 32'h22, 32'h44);
      run_dump(0, -1, 32'h77, "pre_abort");
      begin
         int cyc;
         bit hit;
         cyc = 0; hit = 0;
         a_start = 1'b1;
         step();
         a_start = 1'b0;
         while (!hit && cyc < 200) begin
            a_ready = 1'b1;
            if (a_valid && a_idx == 5) begin
               hit = 1'b1;
               a_abort = 1'b1;
            end
            step();
            cyc++;
         end
         a_abort = 1'b0;
         a_ready = 1'b0;
         chk("abort reached idx5", 32'(hit), 32'd1);
         chk("abort valid", 32'(a_valid), 32'd0);
         chk("abort busy", 32'(a_busy), 32'd0);
         chk("abort sel", 32'(a_sel), 32'd0);
         chk("abort done", 32'(a_done), 32'd0);
         chk("abort checksum", a_chk, 32'h77);
         step();
         chk("abort done_later", 32'(a_done), 32'd0);
         chk("abort stays_idle", 32'(a_busy), 32'd0);
      end
      regs_a[7] = 32'h100;
      run_dump(0, -1, 32'h177, "post_abort");

      // Settle latency on instance B (SETTLE_CYCLES = 3)
      b_ready = 1'b1;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("settle3 w%0d gap%0d", w, k), 32'(b_valid), 32'd0);
            step();
         end
         chk($sformatf("settle3 w%0d valid", w), 32'(b_valid), 32'd1);
         chk($sformatf("settle3 w%0d idx", w), 32'(b_idx), 32'(w));
         chk($sformatf("settle3 w%0d data", w), b_data, regs_b[w]);
         step();
      end
      b_abort = 1'b1;
      step();
      b_abort = 1'b0;
      chk("settle3 abort idle", 32'(b_busy), 32'd0);

      // Asynchronous reset mid-dump
      a_ready = 1'b1;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 9; i++) step();
      chk("pre_reset busy", 32'(a_busy), 32'd1);
      rstn = 1'b0;
      #1;
      chk("async_reset sel", 32'(a_sel), 32'd0);
      chk("async_reset valid", 32'(a_valid), 32'd0);
      chk("async_reset data", a_data, 32'd0);
      chk("async_reset idx", 32'(a_idx), 32'd0);
      chk("async_reset last", 32'(a_last), 32'd0);
      chk("async_reset busy", 32'(a_busy), 32'd0);
      chk("async_reset done", 32'(a_done), 32'd0);
      chk("async_reset checksum", a_chk, 32'd0);
      step();
      chk("reset_held no_done", 32'(a_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Hardware initiator for the CPU's debug register-read port (reg_sel out, reg_data in).
- On a start request it sweeps reg_sel through 0..NUM_REGS-1 and waits a settle interval per register.
- Each word is captured and streamed out over a valid/ready interface, with a running XOR checksum.
- Sits between pipeline_sccomp's debug port and a downstream consumer (UART framer / trace FIFO), replacing manual reg_sel poking.

Parameters:
- NUM_REGS, 32, number of registers swept, starting at index 0; range 2..32.
- SEL_W, 5, width of reg_sel / out_idx.
- SETTLE_CYCLES, 1, clocks reg_sel is held stable before reg_data is sampled; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; takes priority over all other events.
- reg_sel  output  SEL_W  register index driven to the CPU debug port.
- reg_data  input  32  register contents from the CPU; combinational from reg_sel.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  32  captured register value.
- out_idx  output  SEL_W  index of the register in out_data.
- out_last  output  1  high with out_valid on the word for index NUM_REGS-1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.
- checksum  output  32  XOR of all words in the last completed dump.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE.
  - reg_sel, out_data, out_idx, checksum, internal accumulator and settle counter = 0.
  - out_valid, out_last, busy, done = 0.
- FSM states: IDLE, SETTLE, SEND.
- IDLE:
  - reg_sel=0, out_valid=0.
  - On start=1: accumulator<=0, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
  - checksum is unchanged on start.
- SETTLE:
  - reg_sel is held constant.
  - If counter!=0: decrement.
  - If counter==0: out_data<=reg_data, out_idx<=reg_sel, out_last<=(reg_sel==NUM_REGS-1), out_valid<=1, go to SEND.
  - out_valid therefore rises exactly SETTLE_CYCLES clock edges after the edge that entered SETTLE.
- SEND:
  - out_data/out_idx/out_last are held stable while out_valid=1 and out_ready=0. No drop, no change.
  - On out_valid&&out_ready: accumulator<=accumulator^out_data and out_valid<=0.
    - If out_last: checksum<=accumulator^out_data, done<=1 for the next cycle, reg_sel<=0, go to IDLE.
    - Else: reg_sel<=reg_sel+1, counter<=SETTLE_CYCLES-1, go to SETTLE.
- The bubble between accepted words is SETTLE_CYCLES cycles; out_valid never stays high across two words.
- start while busy is ignored; there is no queuing.
- abort=1 in any state:
  - Next edge: IDLE, out_valid=0, reg_sel=0, done=0.
  - checksum keeps its previous completed value; the partial accumulator is discarded.
- abort and a handshake in the same cycle: abort wins; the word counts as not transferred and done does not fire.
- out_ready is ignored when out_valid=0.
- busy=0 in the cycle done is high. start may be accepted in that same cycle.
- reg_sel never exceeds NUM_REGS-1; there is no wrap-around within a dump.
- Reset asserted mid-dump returns to reset values immediately; no done pulse.

Test Plan:
- CPU stub with r1=0x11, r2=0x22, r3=0x44, all others 0; SETTLE_CYCLES=1; out_ready tied 1; pulse start.
  - Required: 32 words, out_idx 0..31 in order.
  - out_last only on idx 31; done pulses once; checksum=0x00000077; busy low after done.
- Same stub, out_ready toggling 1,0,0,1,...
  - Required: out_data/out_idx stable while stalled; no word lost or duplicated; checksum=0x00000077.
- SETTLE_CYCLES=3, start at cycle 0.
  - Required: first out_valid rises after edge 3.
  - Each subsequent out_valid rises exactly 3 cycles after the previous accepting edge.
- Assert abort while out_idx=5 is valid with out_ready=1.
  - Required: no transfer of idx 5, no done, IDLE next cycle, checksum still 0x77 from the prior run.
- Start a dump, then pulse start again at idx 10.
  - Required: the second start is ignored and the sweep completes normally. Then drop rstn mid-second dump: all outputs 0 immediately.
- Full dump executed on a live pipeline_sccomp after 200 ns of run time.
  - Required: every captured word equals the bench's own reg_sel/reg_data read of the same register.
